cip_lip_stage: RTL and testbench

//  Instruction-issue front end. Takes 16-bit parcels from the instruction buffers, holds the

---
 rtl/cray_issue_pkg.sv | 35 +++
 rtl/cip_lip_stage_if.sv | 32 +++
 rtl/parcel_fifo.sv | 52 +++++
 rtl/cip_lip_stage.sv | 123 ++++++++++++
 tb/tb_cip_lip_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cray_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cray_issue_pkg
// Description : Shared types, opcode classes and FSM encoding for the
//               CIP/LIP issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package cray_issue_pkg;

    localparam int PARCEL_W = 16;

    // Two-parcel opcode classes (octal): 006-021 is contiguous, then 040-041, 100-137
    localparam logic [6:0] c_op_2p_a_lo = 7'o006;
    localparam logic [6:0] c_op_2p_a_hi = 7'o021;
    localparam logic [6:0] c_op_2p_b_lo = 7'o040;
    localparam logic [6:0] c_op_2p_b_hi = 7'o041;
    localparam logic [6:0] c_op_2p_c_lo = 7'o100;
    localparam logic [6:0] c_op_2p_c_hi = 7'o137;

    typedef logic [PARCEL_W-1:0] parcel_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    function automatic logic is_two_parcel(input logic [6:0] opcode);
        return ((opcode >= c_op_2p_a_lo) && (opcode <= c_op_2p_a_hi)) ||
               ((opcode >= c_op_2p_b_lo) && (opcode <= c_op_2p_b_hi)) ||
               ((opcode >= c_op_2p_c_lo) && (opcode <= c_op_2p_c_hi));
    endfunction

endpackage
`default_nettype wire

// File: rtl/cip_lip_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : cip_lip_stage_if
// Description : Parcel fetch and issue handshake bundle of the CIP/LIP stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface cip_lip_stage_if;
    import cray_issue_pkg::*;

    parcel_t    i_nip;
    logic       i_nip_vld;
    logic       o_nip_rdy;
    logic       i_issue;
    logic       i_flush;
    parcel_t    o_cip;
    logic       o_cip_vld;
    parcel_t    o_lip;
    logic       o_lip_vld;
    logic [1:0] o_p_inc;

    modport master (
        output i_nip, i_nip_vld, i_issue, i_flush,
        input  o_nip_rdy, o_cip, o_cip_vld, o_lip, o_lip_vld, o_p_inc
    );

    modport slave (
        input  i_nip, i_nip_vld, i_issue, i_flush,
        output o_nip_rdy, o_cip, o_cip_vld, o_lip, o_lip_vld, o_p_inc
    );

endinterface
`default_nettype wire

// File: rtl/parcel_fifo.sv
`default_nettype none
// ============================================================================
// Module      : parcel_fifo
// Description : Synchronous parcel prefetch FIFO with wrap-bit pointers.
// Revision    : 1.0 - initial release
// ============================================================================
module parcel_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int              c_aw      = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_ptr_one = (c_aw+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !i_clr) r_mem[r_wr_ptr[c_aw-1:0]] <= i_wdata;
    end

    // Extra pointer bit distinguishes full from empty when the indices match
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign o_rdata = r_mem[r_rd_ptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/cip_lip_stage.sv
`default_nettype none
// ============================================================================
// Module      : cip_lip_stage
// Description : Instruction-issue front end holding the current and lower
//               instruction parcels, fed by a small prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module cip_lip_stage
    import cray_issue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cip_lip_stage_if.slave bus
);
    stage_state_e r_state, w_state_nxt;
    parcel_t      r_cip, w_cip_nxt;
    parcel_t      r_lip, w_lip_nxt;
    logic [1:0]   r_p_inc, w_p_inc_nxt;

    parcel_t w_head;
    parcel_t w_take_data;
    logic    w_full, w_empty;
    logic    w_need, w_pop, w_nip_rdy, w_push_ok, w_bypass, w_take, w_fifo_push;
    logic    w_cip_two, w_take_two, w_issue_ok;

    assign w_cip_two  = is_two_parcel(r_cip[PARCEL_W-1 -: 7]);
    assign w_issue_ok = (r_state == FULL) && bus.i_issue;
    assign w_need     = (r_state != FULL) || bus.i_issue;

    // An empty FIFO forwards the incoming parcel straight into CIP/LIP
    assign w_pop       = w_need && !w_empty && !bus.i_flush;
    assign w_nip_rdy   = !w_full || w_pop;
    assign w_push_ok   = bus.i_nip_vld && w_nip_rdy;
    assign w_bypass    = w_need && w_empty && w_push_ok && !bus.i_flush;
    assign w_take      = w_pop || w_bypass;
    assign w_take_data = w_empty ? bus.i_nip : w_head;
    assign w_take_two  = is_two_parcel(w_take_data[PARCEL_W-1 -: 7]);
    assign w_fifo_push = w_push_ok && !w_bypass && !bus.i_flush;

    parcel_fifo #(
        .WIDTH (PARCEL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (bus.i_flush),
        .i_push  (w_fifo_push),
        .i_pop   (w_pop),
        .i_wdata (bus.i_nip),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cip_nxt   = r_cip;
        w_lip_nxt   = r_lip;
        w_p_inc_nxt = 2'd0;
        if (w_issue_ok) w_p_inc_nxt = w_cip_two ? 2'd2 : 2'd1;

        if (bus.i_flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_take) begin
                        w_cip_nxt   = w_take_data;
                        w_state_nxt = w_take_two ? HALF : FULL;
                    end
                end
                HALF: begin
                    if (w_take) begin
                        w_lip_nxt   = w_take_data;
                        w_state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (bus.i_issue) begin
                        if (w_take) begin
                            w_cip_nxt   = w_take_data;
                            w_state_nxt = w_take_two ? HALF : FULL;
                        end else begin
                            w_state_nxt = EMPTY;
                        end
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cip   <= '0;
            r_lip   <= '0;
            r_p_inc <= 2'd0;
        end else begin
            r_cip   <= w_cip_nxt;
            r_lip   <= w_lip_nxt;
            r_p_inc <= w_p_inc_nxt;
        end
    end

    assign bus.o_nip_rdy = w_nip_rdy;
    assign bus.o_cip     = r_cip;
    assign bus.o_lip     = r_lip;
    assign bus.o_cip_vld = (r_state == FULL);
    assign bus.o_lip_vld = (r_state == FULL) && w_cip_two;
    assign bus.o_p_inc   = r_p_inc;

endmodule
`default_nettype wire

// File: tb/tb_cip_lip_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_cip_lip_stage
// Description : Self-checking bench for cip_lip_stage against a parcel-queue
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cip_lip_stage;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cip_lip_stage_if bus();

    cip_lip_stage #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: every accepted, not yet consumed parcel in program order
    logic [15:0] pq[$];
    bit          lip_held = 1'b0;
    int          m_pinc   = 0;
    logic        last_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic int plen(input logic [15:0] p);
        logic [6:0] op;
        op = p[15:9];
        return (op inside {7'o006, 7'o007, [7'o010:7'o017], 7'o020, 7'o021,
                           7'o040, 7'o041, [7'o100:7'o137]}) ? 2 : 1;
    endfunction

    function automatic bit m_cv();
        return (pq.size() > 0) && ((plen(pq[0]) == 1) || lip_held);
    endfunction

    function automatic int m_fifo_occ();
        if (pq.size() == 0) return 0;
        return pq.size() - (((plen(pq[0]) == 2) && lip_held) ? 2 : 1);
    endfunction

    // Entered and left at a falling edge
    task automatic cycle(input bit v, input logic [15:0] d, input bit iss, input bit fl);
        bit cv, need, rdy, acc, issued, fresh;
        int l0, occ;
        cv  = m_cv();
        l0  = (pq.size() > 0) ? plen(pq[0]) : 1;
        occ = m_fifo_occ();
        chk("cip_vld", 32'(bus.o_cip_vld), 32'(cv));
        chk("lip_vld", 32'(bus.o_lip_vld), 32'(cv && (l0 == 2)));
        chk("p_inc",   32'(bus.o_p_inc),   32'(m_pinc));
        if (pq.size() > 0)     chk("cip", 32'(bus.o_cip), 32'(pq[0]));
        if (cv && (l0 == 2))   chk("lip", 32'(bus.o_lip), 32'(pq[1]));
        bus.i_nip_vld = v;
        bus.i_nip     = d;
        bus.i_issue   = iss;
        bus.i_flush   = fl;
        #1;
        need     = !cv || iss;
        rdy      = (occ < DEPTH) || (need && (occ > 0) && !fl);
        last_rdy = bus.o_nip_rdy;
        chk("nip_rdy", 32'(bus.o_nip_rdy), 32'(rdy));
        acc    = v && rdy;
        issued = cv && iss;
        @(posedge clk);
        m_pinc = issued ? l0 : 0;
        if (fl) begin
            pq.delete();
            lip_held = 1'b0;
        end else begin
            fresh = (pq.size() == 0) || issued;
            if (issued) for (int k = 0; k < l0; k++) void'(pq.pop_front());
            if (acc) pq.push_back(d);
            lip_held = !fresh && (pq.size() >= 2);
        end
        @(negedge clk);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_cip"},     32'(bus.o_cip),     32'h0);
        chk({tag, "_lip"},     32'(bus.o_lip),     32'h0);
        chk({tag, "_cip_vld"}, 32'(bus.o_cip_vld), 32'h0);
        chk({tag, "_lip_vld"}, 32'(bus.o_lip_vld), 32'h0);
        chk({tag, "_p_inc"},   32'(bus.o_p_inc),   32'h0);
    endtask

    initial begin
        logic [15:0] p;
        bus.i_nip_vld = 1'b0;
        bus.i_nip     = '0;
        bus.i_issue   = 1'b0;
        bus.i_flush   = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        #1 chk("reset_rdy", 32'(bus.o_nip_rdy), 32'h1);
        @(negedge clk);

        // Alternating single-parcel instructions issued every clock
        cycle(1'b1, 16'o000120, 1'b0, 1'b0);
        chk("t1_vld0", 32'(bus.o_cip_vld), 32'h1);
        chk("t1_cip0", 32'(bus.o_cip), 32'o000120);
        for (int i = 0; i < 6; i++) begin
            p = (i % 2 == 0) ? 16'o000121 : 16'o000120;
            cycle(1'b1, p, 1'b1, 1'b0);
            chk("t1_pinc", 32'(bus.o_p_inc), 32'h1);
            chk("t1_cip",  32'(bus.o_cip),   32'(p));
        end
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Two-parcel instruction whose LIP arrives three cycles later
        cycle(1'b1, 16'o020100, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t2_half", 32'(bus.o_cip_vld), 32'h0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("t2_cip_vld", 32'(bus.o_cip_vld), 32'h1);
        chk("t2_lip_vld", 32'(bus.o_lip_vld), 32'h1);
        chk("t2_lip",     32'(bus.o_lip),     32'h1234);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_pinc", 32'(bus.o_p_inc), 32'h2);

        // Fill the FIFO with no issue, then free one slot by issuing
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
            chk("t3_rdy", 32'(last_rdy), (i < 5) ? 32'h1 : 32'h0);
        end
        cycle(1'b1, 16'h0106, 1'b1, 1'b0);
        chk("t3_rdy_pop", 32'(last_rdy), 32'h1);
        repeat (6) cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // Flush in HALF with a parcel pushed the same cycle
        cycle(1'b1, 16'o020100, 1'b0, 1'b0);
        cycle(1'b1, 16'h5555, 1'b0, 1'b1);
        chk("t4_vld", 32'(bus.o_cip_vld), 32'h0);
        cycle(1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0001, 1'b0, 1'b0);
        chk("t4_cip", 32'(bus.o_cip), 32'h0001);

        // Flush together with an issue in FULL
        cycle(1'b1, 16'h0003, 1'b1, 1'b1);
        chk("t5_pinc", 32'(bus.o_p_inc), 32'h1);
        chk("t5_vld",  32'(bus.o_cip_vld), 32'h0);

        // Randomised traffic with a mid-stream asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2 rst_n = 1'b0;
                bus.i_nip_vld = 1'b0;
                bus.i_issue   = 1'b0;
                bus.i_flush   = 1'b0;
                #1 chk_zero_outputs("async_rst");
                pq.delete();
                lip_held = 1'b0;
                m_pinc   = 0;
                @(negedge clk);
                rst_n = 1'b1;
                cycle(1'b1, 16'h0042, 1'b0, 1'b0);
                chk("rst_first_cip", 32'(bus.o_cip), 32'h0042);
                chk("rst_first_vld", 32'(bus.o_cip_vld), 32'h1);
            end
            cycle($urandom_range(0, 3) != 0,
                  16'($urandom),
                  (n < 1000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 31) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
